// File: rtl/fp_compare_pipe_if.sv
// fp_compare_pipe_if: valid/ready bundle for the floating-point compare pipe.
// Ports (signals):
//   in_valid/in_ready, op, inA, inB : operation request and its handshake
//   out_valid/out_ready             : result handshake
//   result, sel, unordered          : predicate outcome, selected operand, NaN flag
// W is the operand width, WE+WF+3, and must match the attached comparator.
interface fp_compare_pipe_if #(
  parameter int unsigned W = 37
) ();
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic         out_valid;
  logic         out_ready;
  logic         result;
  logic [W-1:0] sel;
  logic         unordered;

  // Requester side: issues operations, consumes results.
  modport master (
    output in_valid, op, inA, inB, out_ready,
    input  in_ready, out_valid, result, sel, unordered
  );

  // Comparator side.
  modport slave (
    input  in_valid, op, inA, inB, out_ready,
    output in_ready, out_valid, result, sel, unordered
  );
endinterface

// File: rtl/fp_compare_pipe.sv
// fp_compare_pipe: pipelined FloPoCo-format comparator and min/max unit.
// Evaluates ordered predicates directly on the encodings (no subtractor).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears every stage
//   bus  : fp_compare_pipe_if slave (request handshake, op, operands, results)
// Parameters: WE exponent width, WF fraction width, LAT stages (1..4).
module fp_compare_pipe #(
  parameter int unsigned WE  = 11,
  parameter int unsigned WF  = 23,
  parameter int unsigned LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  fp_compare_pipe_if.slave  bus
);
  localparam int unsigned W  = WE + WF + 3;
  localparam int unsigned FW = WE + WF;
  localparam int unsigned KW = FW + 2;

  localparam logic [2:0] OP_LT = 3'd0;
  localparam logic [2:0] OP_LE = 3'd1;
  localparam logic [2:0] OP_EQ = 3'd2;
  localparam logic [2:0] OP_NE = 3'd3;
  localparam logic [2:0] OP_GT = 3'd4;
  localparam logic [2:0] OP_GE = 3'd5;
  localparam logic [2:0] OP_MIN = 3'd6;

  localparam logic [W-1:0] CANON_NAN = {2'b11, {(W-2){1'b0}}};

  typedef struct packed {
    logic         v;
    logic         lt;
    logic         eq;
    logic         un;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } stage_t;

  // Stage 0 is the entry stage, stage LAT-1 drives the outputs.
  stage_t [LAT-1:0] pipe_q;
  stage_t [LAT-1:0] pipe_d;
  stage_t           first_c;
  stage_t           last;
  logic             stall_c;

  // Encoding-domain compare of the incoming pair.
  logic [1:0]    ea, eb;
  logic          sa, sb;
  logic [KW-1:0] ka, kb;
  logic          a_nan, b_nan, both_zero;

  always_comb begin
    ea = bus.inA[W-1:W-2];
    eb = bus.inB[W-1:W-2];
    sa = bus.inA[W-3];
    sb = bus.inB[W-3];
    // Only normals carry exp/frac into the key; zero and inf are canonical.
    ka = (ea == 2'b01) ? {ea, bus.inA[FW-1:0]} : {ea, {FW{1'b0}}};
    kb = (eb == 2'b01) ? {eb, bus.inB[FW-1:0]} : {eb, {FW{1'b0}}};
    a_nan     = (ea == 2'b11);
    b_nan     = (eb == 2'b11);
    both_zero = (ea == 2'b00) && (eb == 2'b00);

    first_c    = '0;
    first_c.v  = bus.in_valid;
    first_c.un = a_nan | b_nan;
    first_c.eq = ~first_c.un & (both_zero | ((sa == sb) & (ka == kb)));
    // Negative operands order by reversed key; mixed signs make the negative one smaller.
    first_c.lt = ~first_c.un & ~both_zero &
                 ((sa & ~sb) | (~sa & ~sb & (ka < kb)) | (sa & sb & (ka > kb)));
    first_c.op = bus.op;
    first_c.a  = bus.inA;
    first_c.b  = bus.inB;
  end

  // Global stall: every stage holds while the output waits.
  assign last    = pipe_q[LAT-1];
  assign stall_c = last.v & ~bus.out_ready;
  assign bus.in_ready  = ~stall_c;
  assign bus.out_valid = last.v;

  // Next-state: shift every stage up by one when not stalled.
  always_comb begin
    pipe_d = pipe_q;
    if (!stall_c) begin
      pipe_d    = pipe_q << $bits(stage_t);
      pipe_d[0] = first_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  // Output decode from the final stage; all fields read 0 without a valid op.
  logic         res_c;
  logic [W-1:0] sel_c;
  logic         un_c;
  logic         gt_c, la_nan, lb_nan;

  always_comb begin
    res_c  = 1'b0;
    sel_c  = '0;
    un_c   = 1'b0;
    gt_c   = ~last.un & ~last.lt & ~last.eq;
    la_nan = (last.a[W-1:W-2] == 2'b11);
    lb_nan = (last.b[W-1:W-2] == 2'b11);
    if (last.v) begin
      un_c = last.un;
      case (last.op)
        OP_LT:   res_c = last.lt;
        OP_LE:   res_c = last.lt | last.eq;
        OP_EQ:   res_c = last.eq;
        OP_NE:   res_c = ~last.eq;
        OP_GT:   res_c = gt_c;
        OP_GE:   res_c = gt_c | last.eq;
        default: begin
          // MIN/MAX: NaN loses to any number; ties pick A as presented.
          if (la_nan && lb_nan) begin
            res_c = 1'b0;
            sel_c = CANON_NAN;
          end else if (la_nan) begin
            res_c = 1'b0;
            sel_c = last.b;
          end else if (lb_nan) begin
            res_c = 1'b1;
            sel_c = last.a;
          end else begin
            res_c = (last.op == OP_MIN) ? (last.lt | last.eq) : (gt_c | last.eq);
            sel_c = res_c ? last.a : last.b;
          end
        end
      endcase
    end
  end

  assign bus.result    = res_c;
  assign bus.sel       = sel_c;
  assign bus.unordered = un_c;
endmodule

// File: tb/tb_fp_compare_pipe.sv
// tb_fp_compare_pipe: randomized and directed bench for fp_compare_pipe,
// scored against a value-domain reference model kept in the bench.
module tb_fp_compare_pipe;
  localparam int unsigned WE   = 11;
  localparam int unsigned WF   = 23;
  localparam int unsigned LAT  = 2;
  localparam int unsigned W    = WE + WF + 3;
  localparam int unsigned FW   = WE + WF;
  localparam int unsigned BIAS = (1 << (WE - 1)) - 1;
  localparam int unsigned TMO  = 4 * LAT + 8;

  localparam logic [2:0] OP_LT = 3'd0, OP_LE = 3'd1, OP_EQ = 3'd2, OP_NE = 3'd3,
                         OP_GT = 3'd4, OP_GE = 3'd5, OP_MIN = 3'd6, OP_MAX = 3'd7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_compare_pipe_if #(.W(W)) bus ();

  fp_compare_pipe #(.WE(WE), .WF(WF), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic         res;
    logic         un;
    logic [W-1:0] sel;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   rx_cnt = 0;

  logic [W-1:0] P1, P2, N1, PZ, NZ, PINF, QNAN;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] e, input logic s, input int unsigned ex);
    return {e, s, WE'(ex), {WF{1'b0}}};
  endfunction

  // Map an operand to a signed integer whose ordering is the numeric ordering.
  function automatic longint val(input logic [W-1:0] x);
    longint m;
    logic [FW-1:0] ef;
    ef = x[FW-1:0];
    case (x[W-1:W-2])
      2'b00:   m = 0;
      2'b01:   m = longint'(ef) + 1;
      default: m = (longint'(1) << FW) + 1;
    endcase
    return x[W-3] ? -m : m;
  endfunction

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   r;
    longint va, vb;
    logic   an, bn;
    an   = (a[W-1:W-2] == 2'b11);
    bn   = (b[W-1:W-2] == 2'b11);
    va   = val(a);
    vb   = val(b);
    r.un  = an | bn;
    r.res = 1'b0;
    r.sel = '0;
    case (o)
      OP_LT: r.res = !r.un && (va <  vb);
      OP_LE: r.res = !r.un && (va <= vb);
      OP_EQ: r.res = !r.un && (va == vb);
      OP_NE: r.res =  r.un || (va != vb);
      OP_GT: r.res = !r.un && (va >  vb);
      OP_GE: r.res = !r.un && (va >= vb);
      default: begin
        if (an && bn)  r.sel = {2'b11, {(W-2){1'b0}}};
        else if (an)   r.sel = b;
        else if (bn) begin r.res = 1'b1; r.sel = a; end
        else begin
          r.res = (o == OP_MIN) ? (va <= vb) : (va >= vb);
          r.sel = r.res ? a : b;
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_opd();
    logic [1:0]  e;
    logic [63:0] r;
    int unsigned k;
    k = $urandom_range(0, 9);
    e = (k < 2) ? 2'b00 : (k < 7) ? 2'b01 : (k < 8) ? 2'b10 : 2'b11;
    r = {$urandom, $urandom};
    if ($urandom_range(0, 2) == 0) r = 64'($urandom_range(0, 3));
    return {e, 1'($urandom_range(0, 1)), FW'(r)};
  endfunction

  task automatic drive_rand();
    logic [W-1:0] a;
    int unsigned  k;
    a = rnd_opd();
    k = $urandom_range(0, 7);
    bus.op  = 3'($urandom_range(0, 7));
    bus.inA = a;
    if (k < 2)       bus.inB = a;
    else if (k == 2) bus.inB = a ^ (W'(1) << (W - 3));
    else             bus.inB = rnd_opd();
  endtask

  // Scoreboard: checks every output cycle, handshake rule and stall stability.
  logic         prev_hold = 1'b0;
  logic         prev_ov, prev_res, prev_un;
  logic [W-1:0] prev_sel;

  always @(negedge clk) begin
    exp_t e;
    chk("in_ready_rule", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
    if (prev_hold) begin
      chk("hold_valid", 64'(bus.out_valid), 64'(prev_ov));
      chk("hold_result", 64'(bus.result), 64'(prev_res));
      chk("hold_sel", 64'(bus.sel), 64'(prev_sel));
      chk("hold_unordered", 64'(bus.unordered), 64'(prev_un));
    end
    if (bus.out_valid) begin
      chk("out_has_pending", 64'(q.size() > 0), 64'(1));
      if (q.size() > 0) begin
        e = q[0];
        chk("result", 64'(bus.result), 64'(e.res));
        chk("unordered", 64'(bus.unordered), 64'(e.un));
        chk("sel", 64'(bus.sel), 64'(e.sel));
        if (bus.out_ready) begin
          void'(q.pop_front());
          rx_cnt++;
        end
      end
    end
    prev_hold = bus.out_valid && !bus.out_ready && !rst;
    prev_ov   = bus.out_valid;
    prev_res  = bus.result;
    prev_sel  = bus.sel;
    prev_un   = bus.unordered;
    if (rst) q.delete();
    else if (bus.in_valid && bus.in_ready) q.push_back(model(bus.op, bus.inA, bus.inB));
  end

  // One op on an idle pipe: pins the model to hand values and checks exact latency.
  task automatic single(input string nm, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic er, input logic eu,
                        input logic [W-1:0] es);
    exp_t m;
    int   n;
    m = model(o, a, b);
    chk({nm, "_model_res"}, 64'(m.res), 64'(er));
    chk({nm, "_model_un"}, 64'(m.un), 64'(eu));
    chk({nm, "_model_sel"}, 64'(m.sel), 64'(es));
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.op = o; bus.inA = a; bus.inB = b; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < int'(TMO)) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'(LAT));
    chk({nm, "_res"}, 64'(bus.result), 64'(er));
    chk({nm, "_un"}, 64'(bus.unordered), 64'(eu));
    chk({nm, "_sel"}, 64'(bus.sel), 64'(es));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm);
    int n;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 4 * int'(TMO)) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_drained"}, 64'(q.size()), 64'(0));
  endtask

  initial begin
    int acc, c, rx0, cnt;
    P1   = mk(2'b01, 1'b0, BIAS);
    P2   = mk(2'b01, 1'b0, BIAS + 1);
    N1   = mk(2'b01, 1'b1, BIAS);
    PZ   = mk(2'b00, 1'b0, 0);
    NZ   = mk(2'b00, 1'b1, 0);
    PINF = mk(2'b10, 1'b0, 0);
    QNAN = mk(2'b11, 1'b0, 0);

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.op = '0; bus.inA = '0; bus.inB = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
    chk("reset_result", 64'(bus.result), 64'(0));
    chk("reset_sel", 64'(bus.sel), 64'(0));
    chk("reset_unordered", 64'(bus.unordered), 64'(0));
    chk("reset_in_ready", 64'(bus.in_ready), 64'(1));

    single("lt_p1_p2",   OP_LT,  P1,   P2,   1'b1, 1'b0, '0);
    single("gt_n1_p1",   OP_GT,  N1,   P1,   1'b0, 1'b0, '0);
    single("ge_inf_p2",  OP_GE,  PINF, P2,   1'b1, 1'b0, '0);
    single("lt_n1_nz",   OP_LT,  N1,   NZ,   1'b1, 1'b0, '0);
    single("eq_pz_nz",   OP_EQ,  PZ,   NZ,   1'b1, 1'b0, '0);
    single("min_pz_nz",  OP_MIN, PZ,   NZ,   1'b1, 1'b0, PZ);
    single("lt_nan_p1",  OP_LT,  QNAN, P1,   1'b0, 1'b1, '0);
    single("ne_nan_nan", OP_NE,  QNAN, QNAN, 1'b1, 1'b1, '0);
    single("max_nan_p2", OP_MAX, QNAN, P2,   1'b0, 1'b1, P2);
    single("min_nan_nan",OP_MIN, QNAN, QNAN, 1'b0, 1'b1, QNAN);

    // Back-pressure: 8 ops back to back, out_ready low for cycles 3..6.
    acc = 0; c = 0; rx0 = rx_cnt;
    while (acc < 8 && c < 60) begin
      @(posedge clk); #1;
      bus.in_valid  = 1'b1;
      drive_rand();
      bus.out_ready = !(c >= 3 && c <= 6);
      @(negedge clk);
      if (bus.in_ready) acc++;
      c++;
    end
    chk("bp_accepted", 64'(acc), 64'(8));
    drain("bp");
    chk("bp_rx_count", 64'(rx_cnt - rx0), 64'(8));

    // Reset with LAT ops in flight: none may emerge afterwards.
    for (int i = 0; i < int'(LAT); i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      drive_rand();
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_result", 64'(bus.result), 64'(0));
    chk("rst_sel", 64'(bus.sel), 64'(0));
    chk("rst_unordered", 64'(bus.unordered), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    cnt = 0;
    repeat (LAT + 3) begin
      @(posedge clk); #1;
      if (bus.out_valid) cnt++;
    end
    chk("rst_no_stale", 64'(cnt), 64'(0));
    single("post_rst_lt", OP_LT, P1, P2, 1'b1, 1'b0, '0);

    // Random traffic with random back-pressure.
    repeat (12000) begin
      @(posedge clk); #1;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      drive_rand();
    end
    drain("random");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fp_compare_pipe.md
# fp_compare_pipe

Parametrised, pipelined floating-point comparator and min/max unit for FloPoCo-format operands (2-bit exception field, sign, WE-bit exponent, WF-bit fraction). It evaluates all ordered predicates directly on the encodings rather than through a subtractor. It accepts one operation per cycle under a valid/ready handshake and serves the ray/AABB slab-test datapath, where it replaces single-predicate subtractor-based less-than checks and produces t_near/t_far min/max selections.

## Interface

Parameters:
- WE, 11, exponent width
- WF, 23, fraction width
- LAT, 2, pipeline latency in cycles, legal range 1..4
- W (derived, not overridable), WE+WF+3, operand width; 37 at defaults

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair and op are valid this cycle
- in_ready  out  1  block can accept an operation this cycle
- op  in  3  operation: 0 LT, 1 LE, 2 EQ, 3 NE, 4 GT, 5 GE, 6 MIN, 7 MAX
- inA  in  W  operand A, FloPoCo encoding {exn[1:0], sign, exp, frac}
- inB  in  W  operand B, same encoding
- out_valid  out  1  result fields valid
- out_ready  in  1  downstream accepts the result this cycle
- result  out  1  predicate outcome; for MIN/MAX, 1 when A is selected
- sel  out  W  selected operand for MIN/MAX; 0 for predicate ops
- unordered  out  1  at least one operand is NaN

## Operation

- Exception field: 00 zero, 01 normal, 10 infinity, 11 NaN.
- Canonicalisation:
  - Zero keeps its sign bit only; exp/frac are forced to 0.
  - Infinity also has exp/frac forced to 0.
  - ±0 compare equal.
- Magnitude key = {exn, exp, frac} after canonicalisation, compared unsigned.
- Ordering (neither operand NaN):
  - Both zero: equal.
  - Signs differ: the negative operand is less.
  - Both positive: ordered by key.
  - Both negative: order is the reverse of the key comparison.
- NaN present:
  - unordered=1.
  - LT/LE/EQ/GT/GE give 0; NE gives 1.
  - MIN/MAX return the non-NaN operand.
  - If both are NaN, sel = canonical NaN {2'b11, all zeros} and result=0.
- Ties on MIN/MAX (including +0 vs −0): A is selected, result=1, sel=inA as presented (original encoding, not canonicalised).
- Pipeline:
  - LAT register stages, each with a valid bit.
  - Stage 1 holds the registered compare flags (lt, eq, unordered) plus op and operands.
  - The final stage drives the outputs.
- Flow control is a global stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - While stalled, every stage holds its contents.
  - Otherwise all stages advance; a bubble (valid=0) enters when in_valid=0.
- A transfer occurs on in_valid & in_ready (input) and on out_valid & out_ready (output).
- Ordering is strictly FIFO, with no reordering or dropping.

## Timing

- Reset (rst high at a clock edge):
  - All stage valid bits clear; outputs are out_valid=0, result=0, sel=0, unordered=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight operations; none emerge afterwards.
- Latency: an op accepted at edge k appears with out_valid=1 after edge k+LAT-1, i.e. it is visible in the cycle following edge k+LAT-1 when no stall occurs.
- Throughput: 1 op/cycle when out_ready is held at 1.
- in_ready depends combinationally on out_valid and out_ready only. There is no path from in_valid to in_ready.
- Output fields stay stable while out_valid=1 and out_ready=0.
- When out_ready returns high, the held result transfers that cycle, and a new input may be accepted in the same cycle.
- Changes to op/inA/inB while in_valid=0 have no effect.

## Test plan

Encodings below are 37-bit hex at defaults: +1.0=0x9FF800000, +2.0=0xA00000000, −1.0=0xDFF800000, +0=0x000000000, −0=0x400000000, +inf=0x1000000000, NaN=0x1800000000.

- Predicates with out_ready=1:
  - LT(+1.0, +2.0) -> result=1, unordered=0, LAT cycles after acceptance.
  - GT(−1.0, +1.0) -> 0.
  - GE(+inf, +2.0) -> 1.
  - LT(−1.0, −0) -> 1.
- Zeros: EQ(+0, −0) -> 1; MIN(+0, −0) -> result=1, sel=0x000000000.
- NaN:
  - LT(NaN, +1.0) -> result=0, unordered=1.
  - NE(NaN, NaN) -> 1.
  - MAX(NaN, +2.0) -> sel=0xA00000000, result=0.
  - MIN(NaN, NaN) -> sel=0x1800000000.
- Back-pressure: stream 8 random ops back to back with out_ready low for cycles 3–6.
  - in_ready is low exactly while out_valid & ~out_ready.
  - All 8 results emerge in order, none lost or duplicated.
  - Outputs stay stable while stalled.
- Reset mid-stream: assert rst for 1 cycle with LAT ops in flight.
  - The next cycle shows out_valid=0 and all outputs 0.
  - No pre-reset result ever appears.
  - The first post-reset op returns after exactly LAT cycles.
- Parameter sweep:
  - Rerun scenarios 1–4 with LAT=1 and LAT=4, and with WE=8, WF=23.
  - Compare against a reference model on 10k random operands, including all exception combinations.
